// File: rtl/uart_rx_core.sv
// 16x-oversampling UART receiver: start validation, LSB-first data, framing/overrun detection.
// Define UART_RX_PARITY_EN to expect one even-parity bit between the data bits and the stop bit.
module uart_rx_core #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_16bd,
    input  logic                 rx,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_e;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_e               state_q, state_d;
    logic                 rxMeta_q, rxSync_q;
    logic [3:0]           tickCnt_q, tickCnt_d;
    logic [2:0]           bitCnt_q, bitCnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] dataOut_q, dataOut_d;
    logic                 dataReady_q, dataReady_d;
    logic                 frameErr_q, frameErr_d;
    logic                 overrunErr_q, overrunErr_d;
    logic                 goodWord;
`ifdef UART_RX_PARITY_EN
    logic                 parityBad_q, parityBad_d;
    logic                 parityErr_q, parityErr_d;
`endif

    always_comb begin
        state_d      = state_q;
        tickCnt_d    = tickCnt_q;
        bitCnt_d     = bitCnt_q;
        shift_d      = shift_q;
        dataOut_d    = dataOut_q;
        dataReady_d  = dataReady_q;
        frameErr_d   = 1'b0;
        overrunErr_d = 1'b0;
        goodWord     = 1'b0;
`ifdef UART_RX_PARITY_EN
        parityBad_d  = parityBad_q;
        parityErr_d  = 1'b0;
`endif
        if (rd_ack) begin
            dataReady_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rxSync_q) begin
                    tickCnt_d = 4'd0;
                    state_d   = START;
                end
            end
            START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (clk_16bd) begin
                    tickCnt_d = tickCnt_q + 4'd1;
                    if (tickCnt_q == 4'd7) begin
                        tickCnt_d = 4'd0;
                        bitCnt_d  = 3'd0;
                        state_d   = rxSync_q ? IDLE : DATA;
                    end
                end
            end
            DATA: begin
                if (clk_16bd) begin
                    tickCnt_d = tickCnt_q + 4'd1;
                    if (tickCnt_q == 4'd15) begin
                        shift_d  = {rxSync_q, shift_q[DATA_BITS-1:1]};
                        bitCnt_d = bitCnt_q + 3'd1;
                        if (bitCnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_16bd) begin
                    tickCnt_d = tickCnt_q + 4'd1;
                    if (tickCnt_q == 4'd15) begin
                        parityBad_d = rxSync_q ^ (^shift_q);
                        state_d     = STOP;
                    end
                end
            end
`endif
            STOP: begin
                if (clk_16bd) begin
                    tickCnt_d = tickCnt_q + 4'd1;
                    if (tickCnt_q == 4'd15) begin
                        if (rxSync_q) begin
                            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                            if (parityBad_q) begin
                                parityErr_d = 1'b1;
                            end else begin
                                goodWord = 1'b1;
                            end
`else
                            goodWord = 1'b1;
`endif
                        end else begin
                            frameErr_d = 1'b1;
                            state_d    = BREAK;
                        end
                    end
                end
            end
            BREAK: begin
                if (rxSync_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A completing word wins over a same-cycle acknowledge.
        if (goodWord) begin
            dataOut_d    = shift_q;
            dataReady_d  = 1'b1;
            overrunErr_d = dataReady_q & ~rd_ack;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rxMeta_q     <= 1'b1;
            rxSync_q     <= 1'b1;
            tickCnt_q    <= 4'd0;
            bitCnt_q     <= 3'd0;
            shift_q      <= '0;
            dataOut_q    <= '0;
            dataReady_q  <= 1'b0;
            frameErr_q   <= 1'b0;
            overrunErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityBad_q  <= 1'b0;
            parityErr_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rxMeta_q     <= rx;
            rxSync_q     <= rxMeta_q;
            tickCnt_q    <= tickCnt_d;
            bitCnt_q     <= bitCnt_d;
            shift_q      <= shift_d;
            dataOut_q    <= dataOut_d;
            dataReady_q  <= dataReady_d;
            frameErr_q   <= frameErr_d;
            overrunErr_q <= overrunErr_d;
`ifdef UART_RX_PARITY_EN
            parityBad_q  <= parityBad_d;
            parityErr_q  <= parityErr_d;
`endif
        end
    end

    assign data_out    = dataOut_q;
    assign data_ready  = dataReady_q;
    assign busy        = (state_q != IDLE);
    assign frame_err   = frameErr_q;
    assign overrun_err = overrunErr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parityErr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule
